// File: rtl/dram_responder.sv
// Line-granular main-memory model behind the L1 cache's DRAM port.
// Accepts one request at a time and holds it for a fixed latency.
// It then performs the read or write and pulses mem_ack for one cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no request held; a high mem_cs is captured on the next edge
// S_WAIT | request captured, counting down the access latency
// S_ACK  | access done, mem_ack high for this single cycle
module dram_responder #(
  parameter int addr_width  = 32,
  parameter int data_width  = 256,
  parameter int index_width = 10,
  parameter int mem_depth   = 1024,
  parameter int latency     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] mem_addr,
  input  logic                  mem_cs,
  input  logic                  mem_we,
  input  logic [data_width-1:0] mem_data_i,
  output logic                  mem_ack,
  output logic [data_width-1:0] mem_data_o,
  output logic                  mem_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  // The counter is loaded with latency-1 so that WAIT lasts exactly latency cycles.
  localparam logic [7:0] load_val = 8'(latency - 1);

  state_t                 state;
  logic [7:0]             count;
  logic [index_width-1:0] idx_q;
  logic                   we_q;
  logic [data_width-1:0]  data_q;

  logic [data_width-1:0]  storage [mem_depth];

  logic [index_width-1:0] req_idx;
  logic                   access_now;
  logic                   unused_addr_bits;

  // Line offset bits and bits above the index field do not select a line,
  // so addresses alias modulo mem_depth lines.
  assign req_idx          = mem_addr[index_width+4:5];
  assign unused_addr_bits = ^{mem_addr[4:0], mem_addr[addr_width-1:index_width+5]};

  // The access happens on the edge that leaves WAIT.
  assign access_now = (state == S_WAIT) && (count == 8'd0);

  // Line storage has no reset. A reset always returns state to IDLE, so an
  // aborted write can never reach the array.
  always_ff @(posedge clk) begin
    if (access_now && we_q) begin
      storage[idx_q] <= data_q;
    end
  end

  // Request sequencing with registered ack/busy/read-data outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      count      <= 8'd0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      mem_ack    <= 1'b0;
      mem_busy   <= 1'b0;
      mem_data_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          mem_ack <= 1'b0;
          if (mem_cs) begin
            idx_q    <= req_idx;
            we_q     <= mem_we;
            data_q   <= mem_data_i;
            count    <= load_val;
            mem_busy <= 1'b1;
            state    <= S_WAIT;
          end else begin
            mem_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (count == 8'd0) begin
            if (!we_q) begin
              mem_data_o <= storage[idx_q];
            end
            mem_ack <= 1'b1;
            state   <= S_ACK;
          end else begin
            count <= count - 8'd1;
          end
        end
        S_ACK: begin
          mem_ack  <= 1'b0;
          mem_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          mem_ack  <= 1'b0;
          mem_busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder. Instance 0 is built with latency 10 and instance 1
// with latency 1. A line-level reference model (an associative array of lines)
// predicts read data. The expected ack latency comes straight from each
// instance's latency parameter.
module tb_dram_responder;

  localparam int LAT0 = 10;
  localparam int LAT1 = 1;

  logic         clk;
  logic         rst;

  logic [31:0]  addr0, addr1;
  logic         cs0, cs1;
  logic         we0, we1;
  logic [255:0] wd0, wd1;
  logic         ack0, ack1;
  logic [255:0] do0, do1;
  logic         busy0, busy1;

  int tests = 0;
  int fails = 0;

  logic [255:0] mdl [int];
  logic [255:0] exp_do [2];
  bit           known  [2];

  dram_responder #(.latency(LAT0)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(addr0), .mem_cs(cs0), .mem_we(we0),
    .mem_data_i(wd0), .mem_ack(ack0), .mem_data_o(do0), .mem_busy(busy0)
  );

  dram_responder #(.latency(LAT1)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr1), .mem_cs(cs1), .mem_we(we1),
    .mem_data_i(wd1), .mem_ack(ack1), .mem_data_o(do1), .mem_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic c, input logic w,
                       input logic [31:0] a, input logic [255:0] d);
    if (sel == 0) begin
      cs0 = c; we0 = w; addr0 = a; wd0 = d;
    end else begin
      cs1 = c; we1 = w; addr1 = a; wd1 = d;
    end
  endtask

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? ack0 : ack1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [255:0] get_do(input int sel);
    return (sel == 0) ? do0 : do1;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete request as the cache would issue it. flip scrambles addr and
  // data while the request waits; keep leaves mem_cs high through the ack cycle.
  task automatic txn(input int sel, input bit we, input logic [31:0] addr,
                     input logic [255:0] wdata, input bit flip, input bit keep);
    int n;
    bit got;
    int lat;
    int key;
    lat = (sel == 0) ? LAT0 : LAT1;
    key = sel * 4096 + int'(addr[14:5]);
    @(negedge clk);
    drive(sel, 1'b1, we, addr, wdata);
    @(posedge clk); #1;
    check("busy_at_accept", 256'(get_busy(sel)), 256'(1));
    check("ack_at_accept", 256'(get_ack(sel)), 256'(0));
    n = 0;
    got = 0;
    while (!got && n < 300) begin
      if (flip) begin
        @(negedge clk);
        drive(sel, 1'b1, we, $urandom, rand_line());
      end
      @(posedge clk); #1;
      n++;
      if (get_ack(sel)) got = 1;
      else check("busy_in_wait", 256'(get_busy(sel)), 256'(1));
    end
    check("ack_latency", 256'(n), 256'(lat));
    if (we) begin
      mdl[key] = wdata;
    end else if (mdl.exists(key)) begin
      exp_do[sel] = mdl[key];
      known[sel]  = 1;
    end else begin
      known[sel] = 0;
    end
    if (known[sel]) check("data_o", get_do(sel), exp_do[sel]);
    check("busy_at_ack", 256'(get_busy(sel)), 256'(1));
    if (!keep) begin
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 32'h0, 256'h0);
    end
    @(posedge clk); #1;
    check("ack_one_cycle", 256'(get_ack(sel)), 256'(0));
    check("busy_after_ack", 256'(get_busy(sel)), 256'(0));
  endtask

  initial begin
    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] line_y;
    logic [255:0] line_x;
    logic [255:0] line_c;
    logic [31:0]  ra;
    int           acks;
    int           idx;
    bit           rwe;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 256'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 256'h0);
    #2 rst = 1'b0;
    #1;
    check("rst_ack0", 256'(ack0), 256'(0));
    check("rst_busy0", 256'(busy0), 256'(0));
    check("rst_do0", do0, 256'h0);
    check("rst_do1", do1, 256'h0);
    exp_do[0] = '0; known[0] = 1;
    exp_do[1] = '0; known[1] = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle with mem_cs low: nothing may happen.
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1 || busy0 || busy1) acks++;
    end
    check("idle_quiet", 256'(acks), 256'(0));

    // Write then read the same line.
    line_a = {8{32'hA5A5_0001}};
    txn(0, 1'b1, 32'h0000_0040, line_a, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h0000_0040, 256'h0, 1'b0, 1'b0);

    // Offset bits set on the write, upper bits set on the read: same line.
    line_b = rand_line();
    txn(0, 1'b1, 32'h0000_005F, line_b, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h0000_8040, 256'h0, 1'b0, 1'b0);

    // Index 3 gets a known line for the reset test below.
    line_y = rand_line();
    txn(0, 1'b1, 32'h0000_0060, line_y, 1'b0, 1'b0);

    // Inputs scrambled during WAIT, then a back-to-back read with mem_cs held.
    txn(0, 1'b0, 32'h0000_8040, 256'h0, 1'b1, 1'b1);
    txn(0, 1'b0, 32'h0000_0060, 256'h0, 1'b0, 1'b0);

    // Reset during the 5th WAIT cycle of a write to index 3.
    line_x = ~line_y;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_0060, line_x);
    @(posedge clk); #1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("wait5_busy", 256'(busy0), 256'(1));
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 256'h0);
    #1;
    check("abort_ack0", 256'(ack0), 256'(0));
    check("abort_busy0", 256'(busy0), 256'(0));
    check("abort_do0", do0, 256'h0);
    exp_do[0] = '0; known[0] = 1;
    exp_do[1] = '0; known[1] = 1;
    @(negedge clk);
    rst = 1'b1;

    // The aborted write must not have reached the array.
    txn(0, 1'b0, 32'h0000_0060, 256'h0, 1'b0, 1'b0);

    // Latency-1 instance: write, read, back-to-back reads.
    line_c = rand_line();
    txn(1, 1'b1, 32'h1234_0020, line_c, 1'b0, 1'b0);
    txn(1, 1'b0, 32'h0000_0020, 256'h0, 1'b0, 1'b1);
    txn(1, 1'b0, 32'hFFFF_8020, 256'h0, 1'b1, 1'b0);

    // Reset while ack is high: ack must fall without waiting for a clock.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h0000_0020, 256'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ack_before_rst", 256'(ack1), 256'(1));
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 32'h0, 256'h0);
    #1;
    check("rst_in_ack_ack1", 256'(ack1), 256'(0));
    check("rst_in_ack_busy1", 256'(busy1), 256'(0));
    check("rst_in_ack_do1", do1, 256'h0);
    exp_do[0] = '0; known[0] = 1;
    exp_do[1] = '0; known[1] = 1;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic on both instances over a few aliasing lines.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 25; i++) begin
        idx = $urandom_range(0, 7);
        ra = $urandom;
        ra[14:5] = 10'(idx);
        rwe = ($urandom_range(0, 1) == 1) || !mdl.exists(s * 4096 + idx);
        txn(s, rwe, ra, rand_line(), $urandom_range(0, 1) == 1,
            (i != 24) && ($urandom_range(0, 1) == 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
